// File: rtl/nkmd_mig_pkg.sv
// Shared definitions for the MIG user-port burst controller: state encodings,
// MIG command codes, error-flag bit positions and the word-to-byte address mapping.
package nkmd_mig_pkg;

  localparam int unsigned AddrW = 25;
  localparam int unsigned BlW   = 6;

  // Controller states (one state register, legacy-compatible constants)
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWrFill  = 3'd1;
  localparam logic [2:0] StWrCmd   = 3'd2;
  localparam logic [2:0] StRdCmd   = 3'd3;
  localparam logic [2:0] StRdDrain = 3'd4;

  // MIG command instruction codes
  localparam logic [2:0] MigInstrWr = 3'b000;
  localparam logic [2:0] MigInstrRd = 3'b001;

  // Sticky error flag positions
  localparam int unsigned ErrWrUnderrun = 0;
  localparam int unsigned ErrWrError    = 1;
  localparam int unsigned ErrRdOverflow = 2;
  localparam int unsigned ErrRdError    = 3;
  localparam int unsigned ErrTimeout    = 4;

  // 32-bit word address to 30-bit MIG byte address
  function automatic logic [29:0] word_to_byte_addr(input logic [AddrW-1:0] word_addr);
    return {3'b000, word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/nkmd_mig_port_ctl_if.sv
// Bundle of request, DMA data-stream, status and MIG user-port signals.
// slave: the controller's view; master: the environment (DMA + MIG) view.
interface nkmd_mig_port_ctl_if;
  import nkmd_mig_pkg::*;

  // Burst request
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [AddrW-1:0] req_word_addr;
  logic [BlW-1:0]   req_bl;
  // Write-data stream
  logic             wr_valid;
  logic             wr_ready;
  logic [31:0]      wr_data;
  // Read-data stream
  logic             rd_valid;
  logic [31:0]      rd_data;
  // Status
  logic             done;
  logic             busy;
  logic [4:0]       err;
  logic             err_clr;
  // MIG command port
  logic             mig_cmd_en;
  logic [2:0]       mig_cmd_instr;
  logic [BlW-1:0]   mig_cmd_bl;
  logic [29:0]      mig_cmd_byte_addr;
  logic             mig_cmd_full;
  // MIG write port
  logic             mig_wr_en;
  logic [3:0]       mig_wr_mask;
  logic [31:0]      mig_wr_data;
  logic             mig_wr_full;
  logic             mig_wr_underrun;
  logic             mig_wr_error;
  // MIG read port
  logic             mig_rd_en;
  logic [31:0]      mig_rd_data;
  logic             mig_rd_empty;
  logic             mig_rd_overflow;
  logic             mig_rd_error;

  modport slave (
    input  req_valid, req_write, req_word_addr, req_bl,
    input  wr_valid, wr_data, err_clr,
    input  mig_cmd_full, mig_wr_full, mig_wr_underrun, mig_wr_error,
    input  mig_rd_data, mig_rd_empty, mig_rd_overflow, mig_rd_error,
    output req_ready, wr_ready, rd_valid, rd_data, done, busy, err,
    output mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr,
    output mig_wr_en, mig_wr_mask, mig_wr_data, mig_rd_en
  );

  modport master (
    output req_valid, req_write, req_word_addr, req_bl,
    output wr_valid, wr_data, err_clr,
    output mig_cmd_full, mig_wr_full, mig_wr_underrun, mig_wr_error,
    output mig_rd_data, mig_rd_empty, mig_rd_overflow, mig_rd_error,
    input  req_ready, wr_ready, rd_valid, rd_data, done, busy, err,
    input  mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr,
    input  mig_wr_en, mig_wr_mask, mig_wr_data, mig_rd_en
  );

endinterface

// File: rtl/nkmd_mig_port_ctl.sv
// Single-burst controller for one MIG user port. A write burst first fills the
// MIG write FIFO, then issues the command; a read burst issues the command, then
// drains the MIG read FIFO with an idle-cycle timeout.
module nkmd_mig_port_ctl
  import nkmd_mig_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input logic                clk,
  input logic                rst,
  nkmd_mig_port_ctl_if.slave bus
);

  localparam int unsigned IdleW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [AddrW-1:0] addr_q;
  logic [BlW-1:0]   bl_q;
  logic             write_q;
  logic [BlW-1:0]   cnt_q, cnt_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             rd_valid_q;
  logic [31:0]      rd_data_q;
  logic             done_q, done_d;
  logic [4:0]       err_q, err_d;

  logic accept, wr_push, cmd_state, cmd_issue, rd_pop, cnt_last, timeout_hit;

  // Handshake and event decode
  always_comb begin
    accept      = bus.req_valid & bus.req_ready;
    wr_push     = (state_q == StWrFill) & ~bus.mig_wr_full & bus.wr_valid;
    cmd_state   = (state_q == StWrCmd) | (state_q == StRdCmd);
    cmd_issue   = cmd_state & ~bus.mig_cmd_full;
    rd_pop      = (state_q == StRdDrain) & ~bus.mig_rd_empty;
    // Terminal when the count equals bl, so bl=63 never wraps the 6-bit counter
    cnt_last    = (cnt_q == bl_q);
    timeout_hit = (state_q == StRdDrain) & bus.mig_rd_empty & (idle_q == IdleLast);
  end

  // Next state, word/idle counters and done pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d  = '0;
        idle_d = '0;
        if (accept) state_d = bus.req_write ? StWrFill : StRdCmd;
      end
      StWrFill: begin
        if (wr_push) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = StWrCmd;
          end else begin
            cnt_d = cnt_q + BlW'(1);
          end
        end
      end
      StWrCmd: begin
        if (cmd_issue) state_d = StIdle;
      end
      StRdCmd: begin
        if (cmd_issue) state_d = StRdDrain;
      end
      StRdDrain: begin
        if (rd_pop) begin
          idle_d = '0;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + BlW'(1);
          end
        end else if (timeout_hit) begin
          idle_d  = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Write done follows the command by one cycle; read done rides with the last rd_valid
    if ((state_q == StWrCmd) && cmd_issue) done_d = 1'b1;
    if (rd_pop && cnt_last) done_d = 1'b1;
  end

  // Sticky error flags; a new event wins over a same-cycle clear
  always_comb begin
    err_d = bus.err_clr ? 5'b0 : err_q;
    err_d[ErrWrUnderrun] = err_d[ErrWrUnderrun] | bus.mig_wr_underrun;
    err_d[ErrWrError]    = err_d[ErrWrError]    | bus.mig_wr_error;
    err_d[ErrRdOverflow] = err_d[ErrRdOverflow] | bus.mig_rd_overflow;
    err_d[ErrRdError]    = err_d[ErrRdError]    | bus.mig_rd_error;
    err_d[ErrTimeout]    = err_d[ErrTimeout]    | timeout_hit;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      bl_q       <= '0;
      write_q    <= 1'b0;
      cnt_q      <= '0;
      idle_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      rd_valid_q <= rd_pop;
      done_q     <= done_d;
      err_q      <= err_d;
      if (accept) begin
        addr_q  <= bus.req_word_addr;
        bl_q    <= bus.req_bl;
        write_q <= bus.req_write;
      end
      if (rd_pop) rd_data_q <= bus.mig_rd_data;
    end
  end

  // Output drive; req_ready is held off while done pulses so IDLE entry precedes accept
  always_comb begin
    bus.req_ready         = (state_q == StIdle) & ~done_q;
    bus.busy              = (state_q != StIdle);
    bus.wr_ready          = (state_q == StWrFill) & ~bus.mig_wr_full;
    bus.rd_valid          = rd_valid_q;
    bus.rd_data           = rd_data_q;
    bus.done              = done_q;
    bus.err               = err_q;
    bus.mig_cmd_en        = cmd_issue;
    bus.mig_cmd_instr     = write_q ? MigInstrWr : MigInstrRd;
    bus.mig_cmd_bl        = bl_q;
    bus.mig_cmd_byte_addr = word_to_byte_addr(addr_q);
    bus.mig_wr_en         = wr_push;
    bus.mig_wr_mask       = 4'b0000;
    bus.mig_wr_data       = bus.wr_data;
    bus.mig_rd_en         = rd_pop;
  end

endmodule
